// File: rtl/cordic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_req_arbiter
// Brief    : Round-robin sharing of one in-order CORDIC core between N_REQ
//            requesters, with a tag FIFO routing results back to their owner.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_req_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [32*N_REQ-1:0]           req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic [31:0]                   core_in_data,
    output logic                          core_in_valid,
    input  logic [31:0]                   core_out_data,
    input  logic                          core_out_valid,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_orphan
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_INFLIGHT);

    localparam logic [ID_W:0]    N_REQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   MAX_W   = (PTR_W+1)'(MAX_INFLIGHT);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             core_in_valid_q, core_in_valid_d;
    logic [31:0]      core_in_data_q, core_in_data_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             err_orphan_q, err_orphan_d;

    logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];

    logic [ID_W:0]    scan_idx;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic             credit_ok;
    logic             issue;
    logic             fifo_empty;
    logic             pop;
    logic [ID_W-1:0]  head_id;
    logic [PTR_W:0]   occupancy;

    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign credit_ok  = (occupancy < MAX_W);
    assign head_id    = tag_mem[rd_ptr_q[PTR_W-1:0]];
    assign pop        = core_out_valid && !fifo_empty;

    // Scan upward from the RR pointer with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= N_REQ_W) begin
                scan_idx = scan_idx - N_REQ_W;
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // Ready is gated by reset so the grant vector drops as soon as reset rises.
    assign issue     = grant_found && credit_ok && !reset;
    assign req_ready = issue ? (N_REQ'(1) << grant_id) : '0;

    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        core_in_valid_d = 1'b0;
        core_in_data_d  = core_in_data_q;
        rsp_valid_d     = '0;
        rsp_data_d      = rsp_data_q;
        err_orphan_d    = err_orphan_q;

        if (issue) begin
            core_in_valid_d = 1'b1;
            core_in_data_d  = req_data[grant_id*32 +: 32];
            wr_ptr_d        = wr_ptr_q + 1'b1;
            rr_ptr_d        = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end

        if (pop) begin
            rsp_valid_d = N_REQ'(1) << head_id;
            rsp_data_d  = core_out_data;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end

        // A result with no outstanding tag has no owner; flag it and drop it.
        if (core_out_valid && fifo_empty) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            core_in_valid_q <= 1'b0;
            core_in_data_q  <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            err_orphan_q    <= 1'b0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            core_in_valid_q <= core_in_valid_d;
            core_in_data_q  <= core_in_data_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            err_orphan_q    <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_q[PTR_W-1:0]] <= grant_id;
        end
    end

    assign core_in_valid = core_in_valid_q;
    assign core_in_data  = core_in_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign inflight      = occupancy;
    assign err_orphan    = err_orphan_q;

endmodule
`default_nettype wire
